key_conditioner: RTL and testbench

Input conditioning stage between the raw DE-series push-buttons and the game datapath. It synchronises the active-low `KEY` pins to `CLOCK_50`, debounces each key independently, and produces a debounced active-high level plus a single-cycle press pulse per key. The datapath consumes the press pulses as player inputs, one pulse per physical press.

---
 rtl/key_conditioner.sv | 127 ++++++++++++
 tb/tb_key_conditioner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, per-key debounce, press/release pulses.
// Optional auto-repeat of key_press while held is enabled by defining KEY_COND_REPEAT_EN.

module key_cond_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef KEY_COND_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          w_s;
  logic          w_flip;

  assign w_s    = ~r_sync[1];
  assign w_flip = (w_s != r_level) && (r_cnt == CMAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_release <= w_flip & r_level;
      // any agreeing sample restarts the stability run
      if ((w_s == r_level) || w_flip) r_cnt <= '0;
      else                            r_cnt <= r_cnt + CW'(1);
      if (w_flip) r_level <= ~r_level;
    end
  end

`ifdef KEY_COND_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rpt_cnt;
  logic          r_rpt_first;
  logic          w_rpt_hit;

  // r_rpt_cnt holds cycles elapsed since the last press/repeat pulse was registered
  assign w_rpt_hit = r_level && !w_flip &&
                     (r_rpt_cnt == (r_rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
      r_press     <= 1'b0;
    end else begin
      r_press <= (w_flip & ~r_level) | w_rpt_hit;
      if (w_flip) begin
        r_rpt_cnt   <= r_level ? '0 : RW'(1);
        r_rpt_first <= 1'b1;
      end else if (w_rpt_hit) begin
        r_rpt_cnt   <= RW'(1);
        r_rpt_first <= 1'b0;
      end else if (r_level) begin
        r_rpt_cnt <= r_rpt_cnt + RW'(1);
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_reset) r_press <= 1'b0;
    else         r_press <= w_flip & ~r_level;
  end
`endif

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
endmodule

module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef KEY_COND_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              any_press
);
  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    key_cond_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_COND_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_lane (
      .i_clk    (CLOCK_50),
      .i_reset  (reset),
      .i_key_n  (KEY[g]),
      .o_level  (key_level[g]),
      .o_press  (key_press[g]),
      .o_release(key_release[g])
    );
  end

  assign any_press = |key_press;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios then random key activity, all cycles
// checked against a pin-history window model.
module tb_key_conditioner;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 10;

  logic         CLOCK_50 = 1'b0;
  logic         reset    = 1'b1;
  logic [N-1:0] KEY      = '1;
  logic [N-1:0] key_level, key_press, key_release;
  logic         any_press;

  key_conditioner #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(D)
`ifdef KEY_COND_REPEAT_EN
    ,
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .KEY        (KEY),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .any_press  (any_press)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  // Model: a key's level flips once the last D synchronised samples all disagree with it.
  // hist bit k is the active-high pin value captured k edges ago (reset edges count as released).
  logic [63:0]  hist [N];
  logic [N-1:0] m_lvl, m_press, m_rel;
  int           held [N];
  int           tmr  [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [63:0] win, full;
    logic        flip;
    full = (64'd1 << D) - 64'd1;
    for (int i = 0; i < N; i++) begin
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      if (reset) begin
        hist[i]  = '0;
        m_lvl[i] = 1'b0;
        held[i]  = 0;
      end else begin
        hist[i] = {hist[i][62:0], ~KEY[i]};
        win     = (hist[i] >> 2) & full;
        flip    = m_lvl[i] ? (win == 64'd0) : (win == full);
        if (flip) begin
          m_press[i] = ~m_lvl[i];
          m_rel[i]   = m_lvl[i];
          m_lvl[i]   = ~m_lvl[i];
          held[i]    = 0;
        end else if (m_lvl[i]) begin
          held[i]++;
`ifdef KEY_COND_REPEAT_EN
          if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0)) m_press[i] = 1'b1;
`endif
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    chk("cycle", {19'd0, key_level, key_press, key_release, any_press},
                 {19'd0, m_lvl, m_press, m_rel, |m_press});
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin hist[i] = '0; held[i] = 0; tmr[i] = 0; end
    m_lvl = '0; m_press = '0; m_rel = '0;

    // reset with keys released, then idle
    reset = 1'b1; KEY = '1;
    repeat (3) step();
    chk("reset_state", {19'd0, key_level, key_press, key_release, any_press}, 32'd0);
    reset = 1'b0;
    repeat (20) step();

    // clean press / release on key 0
    KEY[0] = 1'b0;
    repeat (10) step();
    chk("press_k0", {30'd0, key_level[0], key_press[0]}, 32'd3);
    step();
    chk("press_width", {31'd0, key_press[0]}, 32'd0);
    repeat (20) step();
    KEY[0] = 1'b1;
    repeat (9) step();
    chk("release_early", {31'd0, key_release[0]}, 32'd0);
    step();
    chk("release_k0", {30'd0, key_level[0], key_release[0]}, 32'd1);
    repeat (5) step();

    // bounce on key 1, then settle pressed
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) KEY[1] = ~KEY[1];
      step();
    end
    KEY[1] = 1'b0;
    repeat (9) step();
    chk("bounce_nopulse", {31'd0, key_press[1]}, 32'd0);
    step();
    chk("bounce_press", {31'd0, key_press[1]}, 32'd1);
    KEY[1] = 1'b1;
    repeat (12) step();

    // simultaneous keys 2 and 3
    KEY[3:2] = 2'b00;
    repeat (10) step();
    chk("simul", {27'd0, key_press, any_press}, 32'b11001);
    step();
    chk("simul_width", {27'd0, key_press, any_press}, 32'd0);

    // reset while held, then re-acceptance
    KEY[0] = 1'b0;
    repeat (12) step();
    reset = 1'b1;
    step();
    chk("rst_midhold", {28'd0, key_level}, 32'd0);
    reset = 1'b0;
    repeat (9) step();
    chk("rst_nopulse", {31'd0, key_press[0]}, 32'd0);
    step();
    chk("rst_repress", {31'd0, key_press[0]}, 32'd1);
    KEY = '1;
    repeat (15) step();

    // random activity with mixed bounce/hold lengths and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (tmr[i] == 0) begin
          KEY[i] = ~KEY[i];
          tmr[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 45))
                                               : int'($urandom_range(1, 9));
        end else begin
          tmr[i]--;
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
